// File: rtl/vga_scan_if.sv
// Scan-side bundle shared by the raster generator (master) and the sprite drawers (slave).
interface vga_scan_if;
  logic [9:0] spr_y;
  logic       pix_en;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       spr_start;
  logic       frame_start;

  modport master (
    input  spr_y,
    output pix_en, pixel_x, pixel_y, hsync, vsync, video_on, spr_start, frame_start
  );

  modport slave (
    output spr_y,
    input  pix_en, pixel_x, pixel_y, hsync, vsync, video_on, spr_start, frame_start
  );
endinterface

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel counters, sync/blank decode and the per-frame sprite start strobe.
// Define SYNC_POS_POLARITY_EN for active-high hsync/vsync (default is active-low).
module vga_scan_gen #(
  parameter int RES_H      = 640,
  parameter int RES_V      = 480,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 1,
  parameter int START_LEAD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  vga_scan_if.master scan
);

  localparam int H_TOTAL = RES_H + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = RES_V + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(RES_H);
  localparam logic [9:0] V_VIS    = 10'(RES_V);
  localparam logic [9:0] HS_FIRST = 10'(RES_H + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(RES_H + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(RES_V + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(RES_V + V_FP + V_SYNC - 1);
  localparam logic [9:0] SPR_X    = 10'(H_TOTAL - START_LEAD);

`ifdef SYNC_POS_POLARITY_EN
  localparam logic SYNC_ACTIVE = 1'b1;
`else
  localparam logic SYNC_ACTIVE = 1'b0;
`endif

  localparam logic [0:0] ST_RESET = 1'b0;
  localparam logic [0:0] ST_SCAN  = 1'b1;

  logic [0:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             run;
  logic             pix_en;
  logic [9:0]       next_y;

  assign run    = (state == ST_SCAN);
  assign pix_en = run && (div_cnt == DIV_LAST);
  assign next_y = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;

  // NOTE: every register below uses non-blocking assignment so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= ST_SCAN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 div_cnt <= '0;
    else if (run) begin
      if (div_cnt == DIV_LAST)  div_cnt <= '0;
      else                      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= next_y;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // NOTE: outputs are continuous-assign decodes of registered state, so no latch can form.
  assign scan.pix_en      = pix_en;
  assign scan.pixel_x     = h_cnt;
  assign scan.pixel_y     = v_cnt;
  assign scan.video_on    = run && (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign scan.hsync       = ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign scan.vsync       = ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign scan.frame_start = run && (h_cnt == 10'd0) && (v_cnt == 10'd0) && (div_cnt == '0);

  // Fires on the line before spr_y so the drawer has START_LEAD pixels to arm before pixel_x wraps.
  assign scan.spr_start   = pix_en && (h_cnt == SPR_X) && (next_y == scan.spr_y);

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: default geometry for line timing, a reduced geometry for frame, sprite and divider timing.
module tb_vga_scan_gen;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  logic rst_n_c = 1'b0;

  always #5 clk = ~clk;

  vga_scan_if a_if ();
  vga_scan_if b_if ();
  vga_scan_if c_if ();

  vga_scan_gen u_a (.clk(clk), .rst_n(rst_n_a), .scan(a_if));

  // Small geometry: H_TOTAL=25, V_TOTAL=13, sync lines 9..10, strobe at pixel_x=21.
  vga_scan_gen #(
    .RES_H(16), .RES_V(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_FP(1), .V_SYNC(2), .V_BP(2), .CLK_DIV(1), .START_LEAD(4)
  ) u_b (.clk(clk), .rst_n(rst_n_b), .scan(b_if));

  vga_scan_gen #(
    .RES_H(16), .RES_V(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_FP(1), .V_SYNC(2), .V_BP(2), .CLK_DIV(2), .START_LEAD(4)
  ) u_c (.clk(clk), .rst_n(rst_n_c), .scan(c_if));

  int tests = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag, input logic pe, input logic [9:0] px,
                             input logic [9:0] py, input logic hs, input logic vs,
                             input logic vo, input logic ss, input logic fs);
    check({tag, "_pix_en"}, pe, 0);
    check({tag, "_pixel_x"}, px, 0);
    check({tag, "_pixel_y"}, py, 0);
    check({tag, "_hsync"}, hs, 1);
    check({tag, "_vsync"}, vs, 1);
    check({tag, "_video_on"}, vo, 0);
    check({tag, "_spr_start"}, ss, 0);
    check({tag, "_frame_start"}, fs, 0);
  endtask

  int a_hs_fall = -1, a_hs_rise = -1, a_vo_fall = -1, a_wrap_y = -1, a_wrap_prev_y = -1;
  int a_spr_cnt = 0, a_spr_x = -1, a_spr_y = -1, a_fs_cnt = 0;
  int b_spr_cnt [6];
  int b_spr_x0 = -1, b_spr_y0 = -1, b_spr_x2 = -1, b_spr_y2 = -1;
  int b_vs_lines = 0, b_vs_first = -1, b_wrap_px = -1;
  int b_fs [2];
  int b_fs_n = 0;
  int c_fs [2];
  int c_fs_n = 0;
  int c_spr_cnt = 0, c_spr_pe = -1, c_spr_x = -1;
  logic       a_prev_hs, a_prev_vo;
  logic [9:0] a_prev_px, a_prev_py, b_prev_px, b_prev_py;
  int         found;

  initial begin
    for (int i = 0; i < 6; i++) b_spr_cnt[i] = 0;
    b_fs[0] = -1; b_fs[1] = -1; c_fs[0] = -1; c_fs[1] = -1;
    a_if.spr_y = 10'd1;
    b_if.spr_y = 10'd5;
    c_if.spr_y = 10'd1;

    repeat (3) @(negedge clk);
    check_reset("a_rst", a_if.pix_en, a_if.pixel_x, a_if.pixel_y, a_if.hsync, a_if.vsync,
                a_if.video_on, a_if.spr_start, a_if.frame_start);
    check("c_rst_pix_en", c_if.pix_en, 0);
    check("b_rst_frame_start", b_if.frame_start, 0);

    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
    a_prev_hs = 1'b1; a_prev_vo = 1'b1; a_prev_px = '0; a_prev_py = '0;
    b_prev_px = '0; b_prev_py = '0;

    for (int k = 1; k <= 1700; k++) begin
      int fb;
      @(negedge clk);
      fb = (k - 1) / 325;

      if (k == 1) begin
        check("a_rel_frame_start", a_if.frame_start, 1);
        check("a_rel_video_on", a_if.video_on, 1);
        check("a_rel_pixel_x", a_if.pixel_x, 0);
        check("a_rel_pix_en", a_if.pix_en, 1);
      end
      if (k == 2) check("a_px_step", a_if.pixel_x, 1);
      if (a_prev_hs && !a_if.hsync && a_hs_fall < 0) a_hs_fall = a_if.pixel_x;
      if (!a_prev_hs && a_if.hsync && a_hs_fall >= 0 && a_hs_rise < 0) a_hs_rise = a_if.pixel_x;
      if (a_prev_vo && !a_if.video_on && a_vo_fall < 0) a_vo_fall = a_if.pixel_x;
      if (a_prev_px == 10'd799 && a_if.pixel_x == 10'd0 && a_wrap_y < 0) begin
        a_wrap_y = a_if.pixel_y;
        a_wrap_prev_y = a_prev_py;
      end
      if (a_if.spr_start) begin
        a_spr_cnt++;
        a_spr_x = a_if.pixel_x;
        a_spr_y = a_if.pixel_y;
      end
      if (a_if.frame_start) a_fs_cnt++;

      if (b_if.spr_start) begin
        b_spr_cnt[fb]++;
        if (fb == 0) begin b_spr_x0 = b_if.pixel_x; b_spr_y0 = b_if.pixel_y; end
        if (fb == 2) begin b_spr_x2 = b_if.pixel_x; b_spr_y2 = b_if.pixel_y; end
      end
      if (k <= 325 && b_if.pixel_x == 10'd0 && !b_if.vsync) begin
        b_vs_lines++;
        if (b_vs_first < 0) b_vs_first = b_if.pixel_y;
      end
      if (b_prev_py == 10'd12 && b_if.pixel_y == 10'd0 && b_wrap_px < 0) b_wrap_px = b_prev_px;
      if (b_if.frame_start && b_fs_n < 2) begin b_fs[b_fs_n] = k; b_fs_n++; end

      if (k <= 6) begin
        check($sformatf("c_pix_en_%0d", k), c_if.pix_en, (k % 2 == 0) ? 1 : 0);
        check($sformatf("c_px_hold_%0d", k), c_if.pixel_x, (k - 1) / 2);
      end
      if (k <= 650 && c_if.spr_start) begin
        c_spr_cnt++;
        c_spr_pe = c_if.pix_en;
        c_spr_x = c_if.pixel_x;
      end
      if (c_if.frame_start && c_fs_n < 2) begin c_fs[c_fs_n] = k; c_fs_n++; end

      a_prev_hs = a_if.hsync; a_prev_vo = a_if.video_on;
      a_prev_px = a_if.pixel_x; a_prev_py = a_if.pixel_y;
      b_prev_px = b_if.pixel_x; b_prev_py = b_if.pixel_y;

      // Retarget the small-geometry drawer at each of its frame boundaries.
      if (k % 325 == 0) begin
        case (k / 325)
          2:       b_if.spr_y = 10'd0;
          3:       b_if.spr_y = 10'd20;
          4:       b_if.spr_y = 10'd13;
          default: b_if.spr_y = 10'd5;
        endcase
      end
    end

    check("a_hsync_fall_x", a_hs_fall, 656);
    check("a_hsync_rise_x", a_hs_rise, 752);
    check("a_video_off_x", a_vo_fall, 640);
    check("a_wrap_prev_y", a_wrap_prev_y, 0);
    check("a_wrap_new_y", a_wrap_y, 1);
    check("a_spr_count", a_spr_cnt, 1);
    check("a_spr_x", a_spr_x, 796);
    check("a_spr_y", a_spr_y, 0);
    check("a_frame_start_count", a_fs_cnt, 1);

    check("b_spr_f0_count", b_spr_cnt[0], 1);
    check("b_spr_f0_x", b_spr_x0, 21);
    check("b_spr_f0_y", b_spr_y0, 4);
    check("b_spr_f1_count", b_spr_cnt[1], 1);
    check("b_spr_y0_count", b_spr_cnt[2], 1);
    check("b_spr_y0_x", b_spr_x2, 21);
    check("b_spr_y0_y", b_spr_y2, 12);
    check("b_spr_y20_count", b_spr_cnt[3], 0);
    check("b_spr_y13_count", b_spr_cnt[4], 0);
    check("b_vsync_lines", b_vs_lines, 2);
    check("b_vsync_first", b_vs_first, 9);
    check("b_wrap_px", b_wrap_px, 24);
    check("b_frame_period", b_fs[1] - b_fs[0], 325);

    check("c_frame_period", c_fs[1] - c_fs[0], 650);
    check("c_spr_count", c_spr_cnt, 1);
    check("c_spr_pix_en", c_spr_pe, 1);
    check("c_spr_x", c_spr_x, 21);

    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      @(negedge clk);
      if (b_if.pixel_x == 10'd10 && b_if.pixel_y == 10'd6) found = 1;
    end
    check("b_reach_10_6", found, 1);
    #2 rst_n_b = 1'b0;
    #1;
    check_reset("b_mid", b_if.pix_en, b_if.pixel_x, b_if.pixel_y, b_if.hsync, b_if.vsync,
                b_if.video_on, b_if.spr_start, b_if.frame_start);
    @(negedge clk);
    rst_n_b = 1'b1;
    @(negedge clk);
    check("b_restart_frame_start", b_if.frame_start, 1);
    check("b_restart_px", b_if.pixel_x, 0);
    check("b_restart_py", b_if.pixel_y, 0);
    check("b_restart_video_on", b_if.video_on, 1);
    @(negedge clk);
    check("b_restart_px_next", b_if.pixel_x, 1);
    check("b_restart_fs_clear", b_if.frame_start, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
